// File: rtl/sort_serializer.sv
// sort_serializer: buffers packed result vectors from the pipelined sort
// network and streams them out one element at a time (element 0 first)
// over a valid/ready interface. Results arriving while the buffer is full
// are dropped and flagged with a one-cycle overflow pulse.
//
// Optional feature macro: SORT_SERIALIZER_DROP_CNT_EN
//   defined     -> drop_count is a saturating 16-bit dropped-vector counter
//   not defined -> drop_count is tied to zero and no counter is built
//
// All outputs are registered. The next-state values are computed
// combinationally so that a push on an edge is visible on the outputs
// right after that same edge.
module sort_serializer #(
  parameter int NUM_VALS = 5,
  parameter int SIZE     = 16,
  parameter int DEPTH    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_VALS*SIZE-1:0]      sorted_in,
  input  logic                          done_in,
  output logic [SIZE-1:0]               out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(NUM_VALS)-1:0]   out_index,
  output logic                          out_last,
  output logic [$clog2(DEPTH+1)-1:0]    buf_count,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);

  localparam int IDX_W = $clog2(NUM_VALS);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int VEC_W = NUM_VALS * SIZE;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VALS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Vector storage (not reset; occupancy is tracked by count_r)
  logic [VEC_W-1:0] mem_r [DEPTH];

  // Buffer bookkeeping and registered outputs
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [IDX_W-1:0] idx_r;
  logic             valid_r;
  logic             last_r;
  logic [SIZE-1:0]  data_r;
  logic             overflow_r;
  logic [15:0]      drop_cnt_r;

  // Next-state values
  logic             accept_s;
  logic             pop_s;
  logic             full_eff_s;
  logic             push_s;
  logic             drop_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [IDX_W-1:0] idx_nxt_s;
  logic             head_new_s;
  logic [VEC_W-1:0] head_s;
  logic [SIZE-1:0]  data_nxt_s;

  // Handshake, push/pop/drop decisions and the next head element
  always_comb begin
    accept_s     = valid_r && out_ready;
    pop_s        = accept_s && last_r;
    full_eff_s   = (count_r == FULL_CNT) && !pop_s;
    push_s       = done_in && !full_eff_s;
    drop_s       = done_in && full_eff_s;

    count_nxt_s  = count_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    idx_nxt_s    = idx_r;

    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase

    if (push_s) begin
      wr_ptr_nxt_s = (wr_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_nxt_s = (rd_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    if (accept_s) begin
      idx_nxt_s = last_r ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
    end else begin
      idx_nxt_s = idx_r;
    end

    // The incoming vector becomes the head when nothing else remains after this edge
    head_new_s = push_s && (count_r == (pop_s ? CNT_W'(1) : CNT_W'(0)));

    if (head_new_s) begin
      head_s = sorted_in;
    end else begin
      head_s = mem_r[rd_ptr_nxt_s];
    end

    if (count_nxt_s != {CNT_W{1'b0}}) begin
      data_nxt_s = head_s[int'(idx_nxt_s)*SIZE +: SIZE];
    end else begin
      data_nxt_s = {SIZE{1'b0}};
    end
  end

  // Write accepted vectors into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= sorted_in;
    end
  end

  // Pointer, occupancy and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      data_r     <= {SIZE{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      idx_r      <= idx_nxt_s;
      valid_r    <= (count_nxt_s != {CNT_W{1'b0}});
      last_r     <= (idx_nxt_s == LAST_IDX);
      data_r     <= data_nxt_s;
      overflow_r <= drop_s;
    end
  end

`ifdef SORT_SERIALIZER_DROP_CNT_EN
  // Saturating count of dropped vectors, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_r <= 16'h0000;
    end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'h0001;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end
`else
  assign drop_cnt_r = 16'h0000;
`endif

  assign out_data   = data_r;
  assign out_valid  = valid_r;
  assign out_index  = idx_r;
  assign out_last   = last_r;
  assign buf_count  = count_r;
  assign overflow   = overflow_r;
  assign drop_count = drop_cnt_r;

endmodule

// File: tb/tb_sort_serializer.sv
// Self-checking bench for sort_serializer (default parameters).
// Fixed vector tables, directed multi-cycle sequences and random traffic,
// all compared against a queue-based reference model of the buffer/stream.
module tb_sort_serializer;

  localparam int NV    = 5;
  localparam int SIZE  = 16;
  localparam int DEPTH = 2;
  localparam int VW    = NV * SIZE;

`ifdef SORT_SERIALIZER_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [VW-1:0] sorted_in = '0;
  logic          done_in = 1'b0;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    out_index;
  logic          out_last;
  logic [1:0]    buf_count;
  logic          overflow;
  logic [15:0]   drop_count;

  sort_serializer #(.NUM_VALS(NV), .SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sorted_in(sorted_in), .done_in(done_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_last(out_last), .buf_count(buf_count),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [VW-1:0] mq[$];
  int            m_idx  = 0;
  bit            m_ovf  = 1'b0;
  int            m_drops = 0;

  // elements accepted by the consumer, as seen on the bus
  logic [15:0]   acc_q[$];

  typedef struct {
    logic          done;
    logic [VW-1:0] vec;
    logic          ready;
    logic          exp_valid;
    logic [15:0]   exp_data;
    logic [2:0]    exp_idx;
    logic          exp_last;
    logic [1:0]    exp_cnt;
    logic          exp_ovf;
    logic [15:0]   exp_drop;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic d, input logic [VW-1:0] v, input logic r,
                              input logic ev, input logic [15:0] ed, input logic [2:0] ei,
                              input logic el, input logic [1:0] ec, input logic eo,
                              input logic [15:0] edr);
    vec_t t;
    t.done = d; t.vec = v; t.ready = r; t.exp_valid = ev; t.exp_data = ed;
    t.exp_idx = ei; t.exp_last = el; t.exp_cnt = ec; t.exp_ovf = eo; t.exp_drop = edr;
    return t;
  endfunction

  function automatic logic [15:0] elem(input logic [VW-1:0] v, input int k);
    return v[k*SIZE +: SIZE];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: advance one clock edge from the rules of the stream/buffer
  task automatic model_edge(input logic rst, input logic d, input logic [VW-1:0] v, input logic rdy);
    bit valid, accept, pop, full;
    if (!rst) begin
      mq.delete();
      m_idx = 0; m_ovf = 1'b0; m_drops = 0;
    end else begin
      valid  = (mq.size() != 0);
      accept = valid && rdy;
      pop    = accept && (m_idx == NV - 1);
      if (accept) m_idx = (m_idx == NV - 1) ? 0 : m_idx + 1;
      full   = (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      m_ovf = 1'b0;
      if (d) begin
        if (full) begin
          m_ovf = 1'b1;
          if (DROP_EN && m_drops < 65535) m_drops++;
        end else begin
          mq.push_back(v);
        end
      end
    end
  endtask

  task automatic model_check(input logic rst);
    logic [VW-1:0] h;
    check("valid", 32'(out_valid), 32'(mq.size() != 0));
    check("buf_count", 32'(buf_count), 32'(mq.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_count", 32'(drop_count), 32'(m_drops));
    check("index", 32'(out_index), 32'(m_idx));
    check("last", 32'(out_last), 32'(m_idx == NV - 1));
    if (mq.size() != 0) begin
      h = mq[0];
      check("data", 32'(out_data), 32'(h[m_idx*SIZE +: SIZE]));
    end else if (!rst) begin
      check("reset_data", 32'(out_data), 32'h0);
    end
  endtask

  // one clock: drive inputs, record any acceptance, clock, then compare with the model
  task automatic step(input logic rst, input logic d, input logic [VW-1:0] v, input logic rdy);
    rst_n = rst; done_in = d; sorted_in = v; out_ready = rdy;
    if (rst && rdy && (out_valid === 1'b1)) acc_q.push_back(out_data);
    @(posedge clk);
    model_edge(rst, d, v, rdy);
    #1;
    model_check(rst);
  endtask

  localparam logic [VW-1:0] V1 = 80'h0001_0002_0003_0004_0005;
  localparam logic [VW-1:0] V2 = 80'h1004_1003_1002_1001_1000;
  localparam logic [VW-1:0] V3 = 80'h2004_2003_2002_2001_2000;
  localparam logic [VW-1:0] V4 = 80'h3004_3003_3002_3001_3000;
  localparam logic [VW-1:0] V5 = 80'h4004_4003_4002_4001_4000;
  localparam logic [VW-1:0] V6 = 80'h5004_5003_5002_5001_5000;
  localparam logic [VW-1:0] V7 = 80'h6004_6003_6002_6001_6000;
  localparam logic [VW-1:0] V8 = 80'h7004_7003_7002_7001_7000;
  localparam logic [VW-1:0] V9 = 80'h8004_8003_8002_8001_8000;

  initial begin
    logic [15:0]   dp;
    logic [15:0]   prev_d;
    logic          stalled;
    logic [VW-1:0] rv;
    bit            pat[4];
    dp = DROP_EN ? 16'd1 : 16'd0;

    // single vector, then a 3-deep burst into a 2-deep buffer
    tbl[0]  = mk(1'b1, V1, 1'b1, 1'b1, 16'h0005, 3'd0, 1'b0, 2'd1, 1'b0, 16'd0);
    tbl[1]  = mk(1'b0, '0, 1'b1, 1'b1, 16'h0004, 3'd1, 1'b0, 2'd1, 1'b0, 16'd0);
    tbl[2]  = mk(1'b0, '0, 1'b1, 1'b1, 16'h0003, 3'd2, 1'b0, 2'd1, 1'b0, 16'd0);
    tbl[3]  = mk(1'b0, '0, 1'b1, 1'b1, 16'h0002, 3'd3, 1'b0, 2'd1, 1'b0, 16'd0);
    tbl[4]  = mk(1'b0, '0, 1'b1, 1'b1, 16'h0001, 3'd4, 1'b1, 2'd1, 1'b0, 16'd0);
    tbl[5]  = mk(1'b0, '0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 2'd0, 1'b0, 16'd0);
    tbl[6]  = mk(1'b1, V2, 1'b1, 1'b1, 16'h1000, 3'd0, 1'b0, 2'd1, 1'b0, 16'd0);
    tbl[7]  = mk(1'b1, V3, 1'b1, 1'b1, 16'h1001, 3'd1, 1'b0, 2'd2, 1'b0, 16'd0);
    tbl[8]  = mk(1'b1, V4, 1'b1, 1'b1, 16'h1002, 3'd2, 1'b0, 2'd2, 1'b1, dp);
    tbl[9]  = mk(1'b0, '0, 1'b1, 1'b1, 16'h1003, 3'd3, 1'b0, 2'd2, 1'b0, dp);
    tbl[10] = mk(1'b0, '0, 1'b1, 1'b1, 16'h1004, 3'd4, 1'b1, 2'd2, 1'b0, dp);
    tbl[11] = mk(1'b0, '0, 1'b1, 1'b1, 16'h2000, 3'd0, 1'b0, 2'd1, 1'b0, dp);
    tbl[12] = mk(1'b0, '0, 1'b1, 1'b1, 16'h2001, 3'd1, 1'b0, 2'd1, 1'b0, dp);
    tbl[13] = mk(1'b0, '0, 1'b1, 1'b1, 16'h2002, 3'd2, 1'b0, 2'd1, 1'b0, dp);
    tbl[14] = mk(1'b0, '0, 1'b1, 1'b1, 16'h2003, 3'd3, 1'b0, 2'd1, 1'b0, dp);
    tbl[15] = mk(1'b0, '0, 1'b1, 1'b1, 16'h2004, 3'd4, 1'b1, 2'd1, 1'b0, dp);
    tbl[16] = mk(1'b0, '0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 2'd0, 1'b0, dp);

    // reset state
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_count", 32'(buf_count), 32'h0);
    check("rst_drop", 32'(drop_count), 32'h0);

    // table vectors
    for (int i = 0; i < 17; i++) begin
      step(1'b1, tbl[i].done, tbl[i].vec, tbl[i].ready);
      check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].exp_data));
      check($sformatf("tbl%0d_idx", i), 32'(out_index), 32'(tbl[i].exp_idx));
      check($sformatf("tbl%0d_last", i), 32'(out_last), 32'(tbl[i].exp_last));
      check($sformatf("tbl%0d_cnt", i), 32'(buf_count), 32'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].exp_ovf));
      check($sformatf("tbl%0d_drop", i), 32'(drop_count), 32'(tbl[i].exp_drop));
    end

    // backpressure: ready pattern 1,0,0,1 repeating
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    step(1'b1, 1'b1, V1, 1'b0);
    acc_q.delete();
    prev_d = out_data;
    stalled = 1'b0;
    for (int c = 0; c < 40 && acc_q.size() < 5; c++) begin
      stalled = out_valid && !pat[c % 4];
      prev_d  = out_data;
      step(1'b1, 1'b0, '0, pat[c % 4]);
      if (stalled) check("bp_hold", 32'(out_data), 32'(prev_d));
    end
    check("bp_accepts", 32'(acc_q.size()), 32'd5);
    for (int k = 0; k < 5 && k < acc_q.size(); k++)
      check($sformatf("bp_elem%0d", k), 32'(acc_q[k]), 32'(elem(V1, k)));
    check("bp_empty", 32'(buf_count), 32'h0);

    // full buffer with a pop coinciding with done_in
    step(1'b1, 1'b1, V5, 1'b0);
    step(1'b1, 1'b1, V6, 1'b0);
    check("fp_full", 32'(buf_count), 32'd2);
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, V7, 1'b1);
    check("fp_no_ovf", 32'(overflow), 32'h0);
    check("fp_count", 32'(buf_count), 32'd2);
    check("fp_head", 32'(out_data), 32'(elem(V6, 0)));
    acc_q.delete();
    for (int c = 0; c < 12; c++) step(1'b1, 1'b0, '0, 1'b1);
    check("fp_drained", 32'(acc_q.size()), 32'd10);
    for (int k = 0; k < 10 && k < acc_q.size(); k++)
      check($sformatf("fp_elem%0d", k), 32'(acc_q[k]), 32'(elem(k < 5 ? V6 : V7, k % 5)));

    // reset mid-stream after element 2 is accepted
    step(1'b1, 1'b1, V8, 1'b1);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, '0, 1'b1);
    check("mr_pre_idx", 32'(out_index), 32'd3);
    step(1'b0, 1'b0, '0, 1'b1);
    check("mr_valid", 32'(out_valid), 32'h0);
    check("mr_count", 32'(buf_count), 32'h0);
    check("mr_idx", 32'(out_index), 32'h0);
    step(1'b1, 1'b1, V9, 1'b1);
    check("mr_restart_data", 32'(out_data), 32'(elem(V9, 0)));
    check("mr_restart_idx", 32'(out_index), 32'h0);
    for (int c = 0; c < 6; c++) step(1'b1, 1'b0, '0, 1'b1);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      rv = {$urandom, $urandom, $urandom};
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) < 45), rv,
           ($urandom_range(0, 99) < 65));
    end

    // forced drops with the consumer stalled
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, V1, 1'b0);
    step(1'b1, 1'b1, V2, 1'b0);
`ifdef SORT_SERIALIZER_DROP_CNT_EN
    for (int c = 0; c < 65540; c++) step(1'b1, 1'b1, V3, 1'b0);
    check("sat_drop", 32'(drop_count), 32'h0000FFFF);
`else
    for (int c = 0; c < 10; c++) step(1'b1, 1'b1, V3, 1'b0);
    check("nodrop_cnt", 32'(drop_count), 32'h0);
`endif
    check("drop_ovf", 32'(overflow), 32'h1);
    check("drop_head", 32'(out_data), 32'(elem(V1, 0)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_serializer.md
# sort_serializer

Downstream companion to the pipelined sort network. Captures each packed result vector presented with the sorter's one-cycle completion pulse into a small vector buffer. Emits the vector one element at a time over a valid/ready stream, element 0 (LSB slice) first. The sorter has no backpressure, so this block absorbs bursts and flags any result it is forced to drop.

## Interface
Parameters:
- NUM_VALS, 5, elements per vector (2..16); must match the sorter.
- SIZE, 16, bits per element.
- DEPTH, 2, vector buffer entries (1..8).

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous, active-low reset.
- sorted_in  input  NUM_VALS*SIZE  packed vector; element i is at [i*SIZE +: SIZE].
- done_in  input  1  single-cycle qualifier for sorted_in; may assert on consecutive cycles.
- out_data  output  SIZE  current element.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- out_index  output  $clog2(NUM_VALS)  index of the current element within its vector.
- out_last  output  1  current element is index NUM_VALS-1.
- buf_count  output  $clog2(DEPTH+1)  vectors held, including the one being drained.
- overflow  output  1  one-cycle pulse when a vector is dropped.
- drop_count  output  16  dropped-vector counter (see Configuration).

## Operation
- Buffer: circular FIFO of DEPTH vectors with write pointer, read pointer and count.
  - Push when done_in && !full_eff.
  - full_eff = (count == DEPTH) && !(pop this cycle).
- Pop: occurs on acceptance (out_valid && out_ready) with out_index == NUM_VALS-1.
- Simultaneous push and pop: count is unchanged; both pointers advance and wrap modulo DEPTH.
- Drop: done_in && full_eff discards sorted_in, pulses overflow for one cycle, and leaves buffer contents untouched.
- Serializer:
  - out_valid = (count != 0).
  - out_data = head[out_index*SIZE +: SIZE].
  - out_last = (out_index == NUM_VALS-1).
  - On acceptance, out_index increments; after the last element it returns to 0.
- Stall: while out_valid && !out_ready, out_data, out_index and out_last hold stable.
- Ordering: elements are emitted in buffer order exactly as received. No reordering or comparison is done here.

## Timing
- Reset: on the clk edge with rst_n low, the following clear to 0:
  - count and both pointers;
  - out_index, out_valid, out_last and out_data;
  - buf_count, overflow and drop_count.
- Reset mid-stream discards all buffered vectors and any partially emitted vector. Buffer storage need not be cleared.
- Latency: a push on edge N gives out_valid=1 and element 0 on out_data after edge N. With out_ready held high, element k of that vector is shown after edge N+k.
- Throughput: one element per cycle. A vector occupies NUM_VALS cycles of output bandwidth.
- Back-to-back vectors: the first element of the next vector follows the last element of the current one with no bubble.
- buf_count and overflow are registered. overflow is high during the cycle after the dropping done_in.
- Empty with done_in high: push and out_valid rise after the same edge. No combinational path from done_in to outputs.
- Full with pop in the same cycle as done_in: push accepted, no overflow.

## Configuration
- SORT_SERIALIZER_DROP_CNT_EN defined: drop_count is a 16-bit counter that increments on every drop and saturates at 16'hFFFF. Cleared only by reset.
- Not defined: drop_count is tied to 16'h0000 and the counter logic is not built. The overflow pulse is present in both builds.

## Test plan
- Single vector, NUM_VALS=5, SIZE=16, elements {0x0005,0x0004,0x0003,0x0002,0x0001} from index 0, out_ready=1:
  - out_data reads 0x0005..0x0001 on five consecutive cycles;
  - out_last asserts only with 0x0001;
  - buf_count returns 1→0.
- Backpressure: same vector, out_ready toggled 1,0,0,1,...:
  - each element holds stable while stalled;
  - exactly 5 acceptances;
  - sequence is unchanged.
- Burst, DEPTH=2: done_in on 3 consecutive cycles, out_ready=1:
  - vectors 1 and 2 are emitted in order over 10 cycles;
  - vector 3 is dropped with one overflow pulse;
  - drop_count=1 with the macro, 0 without.
- Full plus pop coincidence: buffer full, done_in asserted in the same cycle as the last element of the head vector is accepted:
  - no overflow;
  - buf_count stays 2;
  - the new vector is emitted after the remaining one.
- Reset mid-stream: rst_n low for one edge after element 2 of a vector is accepted:
  - out_valid=0, buf_count=0, out_index=0;
  - the next vector starts cleanly at element 0.
- Saturation (macro on): 65 540 forced drops → drop_count holds 16'hFFFF.
